// File: rtl/uart_prog_loader.sv
// uart_prog_loader
//   Receives a program image over an 8N1 UART line and writes it into a
//   64-word x 16-bit program memory while holding the CPU.
//   Image format: 0xA5, N (1..64), N x {hi, lo}, checksum (XOR of all
//   hi/lo bytes).
//
// Parameters
//   CLK_HZ     input clock frequency in Hz
//   BAUD       serial bit rate; DIV = CLK_HZ/BAUD (truncated, minimum 4)
//
// Ports
//   CLOCK_50   system clock, rising edge
//   reset_n    asynchronous active-low reset
//   rx         UART receive line, idle high, LSB first
//   mem_addr   program-memory word address being written
//   mem_wdata  instruction word to write
//   mem_we     one-cycle write strobe
//   cpu_hold   high while an image is being loaded
//   load_done  sticky: last image loaded with a correct checksum
//   err        sticky: framing, length or checksum error
//   word_count words written in the current or last load (0..64)
module uart_prog_loader #(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 115200
) (
    input  logic        CLOCK_50,
    input  logic        reset_n,
    input  logic        rx,
    output logic [5:0]  mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_we,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        err,
    output logic [6:0]  word_count
);

    localparam int DIV_RAW = CLK_HZ / BAUD;
    localparam int DIV     = (DIV_RAW < 4) ? 4 : DIV_RAW;
    localparam int HALF    = DIV / 2;
    localparam int CW      = $clog2(DIV);

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [6:0] MAX_WORDS = 7'd64;

    // ------------------------------------------------------------------
    // Input synchronizer and falling-edge detect
    // ------------------------------------------------------------------
    logic [1:0] rx_sync;
    logic       rx_prev;
    logic       rx_s;

    assign rx_s = rx_sync[1];

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            rx_sync <= 2'b11;
            rx_prev <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make both flops sample the
            // pre-edge values, giving a true two-stage shift register.
            rx_sync <= {rx_sync[0], rx};
            rx_prev <= rx_s;
        end
    end

    // ------------------------------------------------------------------
    // UART receiver
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        R_IDLE,
        R_START,
        R_DATA,
        R_STOP
    } rx_state_t;

    rx_state_t      rx_state;
    logic [CW-1:0]  cnt;
    logic [2:0]     bit_idx;
    logic [7:0]     shreg;
    logic [7:0]     rx_byte;
    logic           byte_valid;
    logic           frame_err;

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            rx_state   <= R_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (rx_state)
                R_IDLE: begin
                    // Edge (not level) detect: after a bad stop bit the
                    // line may still be low and must not restart a frame.
                    if (rx_prev && !rx_s) begin
                        rx_state <= R_START;
                        cnt      <= '0;
                    end
                end
                R_START: begin
                    if (cnt == CW'(HALF - 1)) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        // A line already back high at mid-start was a glitch.
                        rx_state <= rx_s ? R_IDLE : R_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                R_DATA: begin
                    if (cnt == CW'(DIV - 1)) begin
                        cnt     <= '0;
                        shreg   <= {rx_s, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7)
                            rx_state <= R_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                R_STOP: begin
                    if (cnt == CW'(DIV - 1)) begin
                        cnt      <= '0;
                        rx_state <= R_IDLE;
                        if (rx_s) begin
                            rx_byte    <= shreg;
                            byte_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: rx_state <= R_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Loader FSM
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        L_IDLE,
        L_LEN,
        L_HI,
        L_LO,
        L_CHK
    } ld_state_t;

    ld_state_t  ld_state;
    logic [6:0] remaining;
    logic [7:0] chk_acc;

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            ld_state   <= L_IDLE;
            remaining  <= '0;
            chk_acc    <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_we     <= 1'b0;
            cpu_hold   <= 1'b0;
            load_done  <= 1'b0;
            err        <= 1'b0;
            word_count <= '0;
        end else begin
            mem_we <= 1'b0;
            if (frame_err) begin
                err      <= 1'b1;
                cpu_hold <= 1'b0;
                ld_state <= L_IDLE;
            end else if (byte_valid) begin
                case (ld_state)
                    L_IDLE: begin
                        if (rx_byte == SYNC_BYTE) begin
                            ld_state   <= L_LEN;
                            cpu_hold   <= 1'b1;
                            load_done  <= 1'b0;
                            err        <= 1'b0;
                            word_count <= '0;
                            chk_acc    <= '0;
                        end
                    end
                    L_LEN: begin
                        if (rx_byte == 8'd0 || rx_byte > {1'b0, MAX_WORDS}) begin
                            err      <= 1'b1;
                            cpu_hold <= 1'b0;
                            ld_state <= L_IDLE;
                        end else begin
                            remaining <= rx_byte[6:0];
                            ld_state  <= L_HI;
                        end
                    end
                    L_HI: begin
                        mem_wdata[15:8] <= rx_byte;
                        chk_acc         <= chk_acc ^ rx_byte;
                        ld_state        <= L_LO;
                    end
                    L_LO: begin
                        // The strobe lands one cycle later with the address
                        // of this word; word_count advances on the same edge.
                        mem_wdata[7:0] <= rx_byte;
                        chk_acc        <= chk_acc ^ rx_byte;
                        mem_we         <= 1'b1;
                        mem_addr       <= word_count[5:0];
                        word_count     <= word_count + 7'd1;
                        remaining      <= remaining - 7'd1;
                        ld_state       <= (remaining == 7'd1) ? L_CHK : L_HI;
                    end
                    L_CHK: begin
                        if (rx_byte == chk_acc)
                            load_done <= 1'b1;
                        else
                            err <= 1'b1;
                        cpu_hold <= 1'b0;
                        ld_state <= L_IDLE;
                    end
                    default: ld_state <= L_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_prog_loader.sv
// tb_uart_prog_loader
//   Directed bench for uart_prog_loader with CLK_HZ=16, BAUD=1 (DIV=16).
//   Bytes are bit-banged onto rx; every mem_we strobe is recorded and the
//   recorded writes and sticky flags are compared against hand-computed
//   images.
module tb_uart_prog_loader;

    localparam int DIV = 16;

    logic        clk;
    logic        reset_n;
    logic        rx;
    logic [5:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic        cpu_hold;
    logic        load_done;
    logic        err;
    logic [6:0]  word_count;

    int n_tests;
    int n_fail;

    logic [5:0]  wr_addr_q[$];
    logic [15:0] wr_data_q[$];

    uart_prog_loader #(
        .CLK_HZ(16),
        .BAUD  (1)
    ) dut (
        .CLOCK_50  (clk),
        .reset_n   (reset_n),
        .rx        (rx),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .cpu_hold  (cpu_hold),
        .load_done (load_done),
        .err       (err),
        .word_count(word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every write strobe, sampled away from the active edge.
    always @(negedge clk) begin
        if (mem_we) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (DIV) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic bad_stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(bad_stop ? 1'b0 : 1'b1);
        rx = 1'b1;
        idle(4);
    endtask

    task automatic send_good(input logic [7:0] b);
        send_byte(b, 1'b0);
    endtask

    task automatic clear_writes();
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    task automatic check_write(input string tag, input int idx,
                               input logic [5:0] a, input logic [15:0] d);
        if (idx < wr_addr_q.size()) begin
            check({tag, "_addr"}, 32'(wr_addr_q[idx]), 32'(a));
            check({tag, "_data"}, 32'(wr_data_q[idx]), 32'(d));
        end else begin
            check({tag, "_present"}, 32'(wr_addr_q.size()), 32'(idx + 1));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_we"},     32'(mem_we),     32'h0);
        check({tag, "_cpu_hold"},   32'(cpu_hold),   32'h0);
        check({tag, "_load_done"},  32'(load_done),  32'h0);
        check({tag, "_err"},        32'(err),        32'h0);
        check({tag, "_word_count"}, 32'(word_count), 32'h0);
        check({tag, "_mem_addr"},   32'(mem_addr),   32'h0);
        check({tag, "_mem_wdata"},  32'(mem_wdata),  32'h0);
    endtask

    // Hard stop in case something stalls the directed sequence.
    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rx      = 1'b1;
        reset_n = 1'b0;
        idle(5);
        check_reset_outputs("reset");
        reset_n = 1'b1;
        idle(20);

        // 1) Good two-word image, checksum 0x12^0x34^0xAB^0xCD = 0x40
        clear_writes();
        send_good(8'hA5);
        send_good(8'h02);
        check("t1_hold_during", 32'(cpu_hold), 32'h1);
        send_good(8'h12);
        send_good(8'h34);
        send_good(8'hAB);
        send_good(8'hCD);
        send_good(8'h40);
        idle(10);
        check("t1_nwrites", 32'(wr_addr_q.size()), 32'd2);
        check_write("t1_w0", 0, 6'd0, 16'h1234);
        check_write("t1_w1", 1, 6'd1, 16'hABCD);
        check("t1_load_done",  32'(load_done),  32'h1);
        check("t1_err",        32'(err),        32'h0);
        check("t1_word_count", 32'(word_count), 32'd2);
        check("t1_cpu_hold",   32'(cpu_hold),   32'h0);

        // 2) Same image, wrong checksum: writes stay, err set
        clear_writes();
        send_good(8'hA5);
        check("t2_done_cleared", 32'(load_done), 32'h0);
        send_good(8'h02);
        send_good(8'h12);
        send_good(8'h34);
        send_good(8'hAB);
        send_good(8'hCD);
        send_good(8'h41);
        idle(10);
        check("t2_nwrites", 32'(wr_addr_q.size()), 32'd2);
        check_write("t2_w0", 0, 6'd0, 16'h1234);
        check_write("t2_w1", 1, 6'd1, 16'hABCD);
        check("t2_err",       32'(err),       32'h1);
        check("t2_load_done", 32'(load_done), 32'h0);
        check("t2_cpu_hold",  32'(cpu_hold),  32'h0);

        // 3) Zero length
        clear_writes();
        send_good(8'hA5);
        check("t3_err_cleared", 32'(err),      32'h0);
        check("t3_hold_set",    32'(cpu_hold), 32'h1);
        send_good(8'h00);
        idle(10);
        check("t3_err",      32'(err),              32'h1);
        check("t3_cpu_hold", 32'(cpu_hold),         32'h0);
        check("t3_nwrites",  32'(wr_addr_q.size()), 32'd0);

        // 3b) Length 65 is rejected as well
        send_good(8'hA5);
        send_good(8'h41);
        idle(10);
        check("t3b_err",      32'(err),              32'h1);
        check("t3b_cpu_hold", 32'(cpu_hold),         32'h0);
        check("t3b_nwrites",  32'(wr_addr_q.size()), 32'd0);

        // 4) Bad stop bit on the HI byte, then the LO byte must be ignored
        clear_writes();
        send_good(8'hA5);
        send_good(8'h01);
        send_byte(8'h12, 1'b1);
        idle(20);
        check("t4_err",      32'(err),      32'h1);
        check("t4_cpu_hold", 32'(cpu_hold), 32'h0);
        send_good(8'h34);
        send_good(8'h99);
        idle(10);
        check("t4_nwrites", 32'(wr_addr_q.size()), 32'd0);
        check("t4_still_idle", 32'(load_done), 32'h0);
        // Recovery: 1-word image 0x5678, checksum 0x56^0x78 = 0x2E
        send_good(8'hA5);
        send_good(8'h01);
        send_good(8'h56);
        send_good(8'h78);
        send_good(8'h2E);
        idle(10);
        check("t4_rec_nwrites", 32'(wr_addr_q.size()), 32'd1);
        check_write("t4_rec_w0", 0, 6'd0, 16'h5678);
        check("t4_rec_done", 32'(load_done), 32'h1);
        check("t4_rec_err",  32'(err),       32'h0);

        // 5) Three-cycle glitch while idle changes nothing
        clear_writes();
        rx = 1'b0;
        idle(3);
        rx = 1'b1;
        idle(3 * DIV);
        check("t5_nwrites",    32'(wr_addr_q.size()), 32'd0);
        check("t5_load_done",  32'(load_done),  32'h1);
        check("t5_err",        32'(err),        32'h0);
        check("t5_cpu_hold",   32'(cpu_hold),   32'h0);
        check("t5_word_count", 32'(word_count), 32'd1);
        // 'A5 A5' after the glitch: second A5 is a length of 165 -> err
        send_good(8'hA5);
        send_good(8'hA5);
        idle(10);
        check("t5_a5_as_len_err", 32'(err), 32'h1);

        // 6) 64-word image, reset in the middle of word 10
        clear_writes();
        send_good(8'hA5);
        send_good(8'h40);
        for (int w = 0; w < 10; w++) begin
            send_good(8'(w + 8'h10));
            send_good(8'(w ^ 8'hA5));
        end
        check("t6_hold_mid", 32'(cpu_hold),   32'h1);
        check("t6_wc_mid",   32'(word_count), 32'd10);
        // Partial HI byte of word 10: start bit plus four data bits
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        reset_n = 1'b0;
        rx      = 1'b1;
        idle(5);
        check_reset_outputs("t6_in_reset");
        reset_n = 1'b1;
        idle(3 * DIV);
        check_reset_outputs("t6_after");
        check("t6_nwrites", 32'(wr_addr_q.size()), 32'd10);
        for (int w = 0; w < 10; w++) begin
            logic [15:0] exp_w;
            exp_w = {8'(w + 8'h10), 8'(w ^ 8'hA5)};
            check_write($sformatf("t6_w%0d", w), w, 6'(w), exp_w);
        end

        // Fresh 1-word image 0xBEEF, checksum 0xBE^0xEF = 0x51
        clear_writes();
        send_good(8'hA5);
        send_good(8'h01);
        send_good(8'hBE);
        send_good(8'hEF);
        send_good(8'h51);
        idle(10);
        check("t6_new_nwrites", 32'(wr_addr_q.size()), 32'd1);
        check_write("t6_new_w0", 0, 6'd0, 16'hBEEF);
        check("t6_new_done", 32'(load_done),  32'h1);
        check("t6_new_err",  32'(err),        32'h0);
        check("t6_new_wc",   32'(word_count), 32'd1);
        check("t6_new_hold", 32'(cpu_hold),   32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_prog_loader.md
UART_PROG_LOADER -- requirements
Module: uart_prog_loader

Interface
REQ-001 The block SHALL provide parameter CLK_HZ, default 50000000, the input clock frequency in Hz.
REQ-002 The block SHALL provide parameter BAUD, default 115200, the serial bit rate; DIV = CLK_HZ/BAUD, truncated integer, minimum 4.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 Port: CLOCK_50  in  1  system clock; all logic on its rising edge.
REQ-005 Port: reset_n  in  1  asynchronous active-low reset.
REQ-006 Port: rx  in  1  UART receive line, idle high, 8N1, LSB first.
REQ-007 Port: mem_addr  out  6  program-memory word address being written.
REQ-008 Port: mem_wdata  out  16  instruction word to write.
REQ-009 Port: mem_we  out  1  one-cycle write strobe to program memory.
REQ-010 Port: cpu_hold  out  1  high while loading; the multicycle CPU holds PC=0 and its state at 0.
REQ-011 Port: load_done  out  1  sticky; set after a valid image with correct checksum.
REQ-012 Port: err  out  1  sticky; set on a framing, length or checksum error.
REQ-013 Port: word_count  out  7  number of words written in the current or last load, 0..64.

Function
REQ-014 rx SHALL pass through a 2-flop synchronizer, reset value 1, before any use.
REQ-015 Receiver: a falling edge while idle starts a frame; rx is re-sampled at DIV/2 and, if high, the start is discarded silently.
REQ-016 Receiver: data bits are sampled at DIV intervals after the start mid-point, and the stop bit one DIV after bit 7.
REQ-017 A stop bit sampled low SHALL discard the byte, set err, and return the loader FSM to IDLE.
REQ-018 A received byte SHALL be presented to the loader FSM as a one-cycle byte_valid in the cycle after the stop-bit sample.
REQ-019 Loader FSM states: IDLE, LEN, HI, LO, CHK.
REQ-020 IDLE: byte 0xA5 -> LEN, assert cpu_hold, clear load_done, err, word_count and the checksum accumulator; any other byte is ignored.
REQ-021 LEN: byte N in 1..64 -> HI with remaining count N; N=0 or N>64 -> set err, deassert cpu_hold, go to IDLE.
REQ-022 HI: byte is latched as mem_wdata[15:8] -> LO.
REQ-023 LO: byte is latched as mem_wdata[7:0]; mem_we is high for exactly the next cycle with mem_addr = word_count[5:0]; word_count then increments.
REQ-024 After the write, the FSM goes to HI if words remain, otherwise to CHK.
REQ-025 The checksum is the XOR of all HI and LO bytes; the LEN and sync bytes are excluded.
REQ-026 CHK: if the byte equals the checksum, set load_done; otherwise set err. In both cases deassert cpu_hold and go to IDLE.
REQ-027 Memory written before a checksum error SHALL NOT be rolled back; err is set and load_done stays 0.
REQ-028 The sync byte 0xA5 received in LEN, HI, LO or CHK SHALL be treated as data, not as a restart.
REQ-029 mem_addr SHALL never exceed 63; no wrap-around is possible because N ≤ 64.
REQ-030 mem_we SHALL never be asserted outside the cycle given in REQ-023.

Reset
REQ-031 reset_n low SHALL force, asynchronously: FSM = IDLE, receiver idle, mem_we=0, cpu_hold=0, load_done=0, err=0, word_count=0, mem_addr=0, mem_wdata=0.
REQ-032 Reset asserted mid-frame or mid-image SHALL abort the load with no further mem_we; after release, the block waits for a new 0xA5.

Verification
REQ-033 With CLK_HZ=16 and BAUD=1 (DIV=16), the bench SHALL cover the following scenarios:
- Send A5 02 12 34 AB CD and checksum 0x12^0x34^0xAB^0xCD = 0x40 -> two mem_we pulses: (0, 0x1234) and (1, 0xABCD); load_done=1, err=0, word_count=2, cpu_hold low after CHK.
- Same image with checksum 0x41 -> both writes occur, err=1, load_done=0.
- Send A5 00 -> err=1, cpu_hold returns 0, no mem_we.
- Corrupt the stop bit of the HI byte -> err=1, FSM in IDLE, no mem_we for that word.
- Glitch rx low for 3 cycles while idle -> no byte_valid and no state change.
- Send A5 40 plus 64 words, then assert reset_n low during word 10 -> exactly 10 writes (addresses 0..9), then all outputs return to reset values; a following valid 1-word image loads at address 0.
